ped_signal_ctrl: RTL and testbench

PED_SIGNAL_CTRL -- requirements
Module: ped_signal_ctrl

---
 rtl/ped_signal_ctrl.sv | 178 +++++++++++++++++
 tb/tb_ped_signal_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing controller slaved to the vehicle lamps of a traffic light.
// Optional push-button debouncer is compiled in when PED_DEBOUNCE_EN is defined.
module ped_signal_ctrl #(
    parameter int WALK_CYCLES     = 6,
    parameter int FLASH_CYCLES    = 4,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_btn,
    input  logic       Red,
    input  logic       Yellow,
    input  logic       Green,
    output logic       Walk,
    output logic       DontWalk,
    output logic       req_pending,
    output logic       fault,
    output logic [3:0] walk_count
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_WALK  = 3'd2,
        S_FLASH = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    function automatic logic is_onehot3(input logic [2:0] v);
        case (v)
            3'b100, 3'b010, 3'b001: is_onehot3 = 1'b1;
            default:                is_onehot3 = 1'b0;
        endcase
    endfunction

    state_t     state_r;
    logic       sync1_r;
    logic       sync2_r;
    logic       btn_prev_r;
    logic       red_q_r;
    logic       fault_ok_r;
    logic       walk_r;
    logic       dont_walk_r;
    logic       req_pending_r;
    logic       fault_r;
    logic [3:0] walk_count_r;
    logic       btn_lvl_s;
    logic       press_s;
    logic       red_rise_s;
    logic       lamps_ok_s;

`ifdef PED_DEBOUNCE_EN
    logic       db_lvl_r;
    logic [3:0] db_cnt_r;

    // Debouncer: adopt the synchronised level once it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_lvl_r <= 1'b0;
            db_cnt_r <= 4'd0;
        end else if (sync2_r == db_lvl_r) begin
            db_cnt_r <= 4'd0;
        end else if (db_cnt_r == 4'(DEBOUNCE_CYCLES - 1)) begin
            db_lvl_r <= sync2_r;
            db_cnt_r <= 4'd0;
        end else begin
            db_cnt_r <= db_cnt_r + 4'd1;
        end
    end

    assign btn_lvl_s = db_lvl_r;
`else
    assign btn_lvl_s = sync2_r;
`endif

    assign press_s    = btn_lvl_s & ~btn_prev_r;
    assign red_rise_s = Red & ~red_q_r;
    assign lamps_ok_s = is_onehot3({Red, Yellow, Green});

    // Input conditioning: button synchroniser, edge history and Red history.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            btn_prev_r <= 1'b0;
            red_q_r    <= 1'b0;
        end else begin
            sync1_r    <= ped_btn;
            sync2_r    <= sync1_r;
            btn_prev_r <= btn_lvl_s;
            red_q_r    <= Red;
        end
    end

    // Crossing FSM with registered lamp, request and count outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            walk_r        <= 1'b0;
            dont_walk_r   <= 1'b1;
            req_pending_r <= 1'b0;
            fault_r       <= 1'b0;
            fault_ok_r    <= 1'b0;
            walk_count_r  <= 4'd0;
        end else if (!lamps_ok_s) begin
            state_r       <= S_FAULT;
            walk_r        <= 1'b0;
            dont_walk_r   <= (state_r == S_FAULT) ? ~dont_walk_r : 1'b1;
            req_pending_r <= 1'b0;
            fault_r       <= 1'b1;
            fault_ok_r    <= 1'b0;
            walk_count_r  <= 4'd0;
        end else begin
            // Idle lamp pattern unless the current state overrides it below.
            state_r       <= state_r;
            walk_r        <= 1'b0;
            dont_walk_r   <= 1'b1;
            req_pending_r <= req_pending_r | press_s;
            fault_r       <= 1'b0;
            fault_ok_r    <= 1'b0;
            walk_count_r  <= 4'd0;
            case (state_r)
                S_IDLE: begin
                    if (req_pending_r) begin
                        state_r <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (red_rise_s) begin
                        state_r       <= S_WALK;
                        walk_r        <= 1'b1;
                        dont_walk_r   <= 1'b0;
                        req_pending_r <= 1'b0;
                        walk_count_r  <= 4'(WALK_CYCLES - 1);
                    end
                end
                S_WALK: begin
                    if (!Red) begin
                        state_r <= S_IDLE;
                    end else if (walk_count_r == 4'd0) begin
                        state_r      <= S_FLASH;
                        walk_count_r <= 4'(FLASH_CYCLES - 1);
                    end else begin
                        walk_r       <= 1'b1;
                        dont_walk_r  <= 1'b0;
                        walk_count_r <= walk_count_r - 4'd1;
                    end
                end
                S_FLASH: begin
                    if (!Red || (walk_count_r == 4'd0)) begin
                        state_r <= S_IDLE;
                    end else begin
                        dont_walk_r  <= ~dont_walk_r;
                        walk_count_r <= walk_count_r - 4'd1;
                    end
                end
                S_FAULT: begin
                    req_pending_r <= 1'b0;
                    if (fault_ok_r) begin
                        state_r <= S_IDLE;
                    end else begin
                        fault_r     <= 1'b1;
                        fault_ok_r  <= 1'b1;
                        dont_walk_r <= ~dont_walk_r;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign Walk        = walk_r;
    assign DontWalk    = dont_walk_r;
    assign req_pending = req_pending_r;
    assign fault       = fault_r;
    assign walk_count  = walk_count_r;
endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Scoreboard bench for ped_signal_ctrl: directed light sequences plus random traffic,
// each cycle's expected lamps come from a behavioural model of the crossing rules.
module tb_ped_signal_ctrl;
    localparam int WALK_CYCLES     = 6;
    localparam int FLASH_CYCLES    = 4;
    localparam int DEBOUNCE_CYCLES = 3;
    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_WALK  = 2;
    localparam int M_FLASH = 3;
    localparam int M_FAULT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ped_btn = 1'b0;
    logic       Red = 1'b0;
    logic       Yellow = 1'b0;
    logic       Green = 1'b1;
    logic       Walk;
    logic       DontWalk;
    logic       req_pending;
    logic       fault;
    logic [3:0] walk_count;

    typedef struct {
        logic       walk;
        logic       dw;
        logic       req;
        logic       flt;
        logic [3:0] wc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;

    // model state: phase, remaining cycles, age in fault, good-lamp run
    int   m_st = M_IDLE;
    int   m_rem = 0;
    int   m_fage = 0;
    int   m_okrun = 0;
    bit   m_req = 1'b0;
    bit   m_red_prev = 1'b0;
    bit   m_pipe[2];
    bit   m_qlvl = 1'b0;
    bit   m_qprev = 1'b0;
    bit   m_shist[$];
    int   btn_hold = 0;
    int   walks_seen = 0;

    ped_signal_ctrl #(
        .WALK_CYCLES    (WALK_CYCLES),
        .FLASH_CYCLES   (FLASH_CYCLES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ped_btn    (ped_btn),
        .Red        (Red),
        .Yellow     (Yellow),
        .Green      (Green),
        .Walk       (Walk),
        .DontWalk   (DontWalk),
        .req_pending(req_pending),
        .fault      (fault),
        .walk_count (walk_count)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit r_i, input bit b_i, input bit rd, input bit yl, input bit gr);
        bit s;
        bit lvl_now;
        bit press;
        bit good;
        bit rise;
        bit all_diff;
        exp_t e;
        if (r_i) begin
            m_st = M_IDLE; m_rem = 0; m_fage = 0; m_okrun = 0; m_req = 1'b0;
            m_red_prev = 1'b0; m_pipe[0] = 1'b0; m_pipe[1] = 1'b0;
            m_qlvl = 1'b0; m_qprev = 1'b0; m_shist.delete();
        end else begin
            s = m_pipe[1];
`ifdef PED_DEBOUNCE_EN
            lvl_now = m_qlvl;
`else
            lvl_now = s;
`endif
            press = lvl_now && !m_qprev;
            good  = ($countones({rd, yl, gr}) == 1);
            rise  = rd && !m_red_prev;
            if (!good) begin
                m_fage  = (m_st == M_FAULT) ? m_fage + 1 : 0;
                m_st    = M_FAULT;
                m_req   = 1'b0;
                m_okrun = 0;
                m_rem   = 0;
            end else if (m_st == M_FAULT) begin
                m_okrun++;
                if (m_okrun >= 2) begin
                    m_st = M_IDLE; m_okrun = 0; m_fage = 0;
                end else begin
                    m_fage++;
                end
            end else begin
                if (m_st == M_IDLE && m_req) m_st = M_ARMED;
                else if (m_st == M_ARMED && rise) begin
                    m_st = M_WALK; m_rem = WALK_CYCLES - 1; walks_seen++;
                end else if (m_st == M_WALK || m_st == M_FLASH) begin
                    if (!rd) begin
                        m_st = M_IDLE; m_rem = 0;
                    end else if (m_rem > 0) begin
                        m_rem--;
                    end else if (m_st == M_WALK) begin
                        m_st = M_FLASH; m_rem = FLASH_CYCLES - 1;
                    end else begin
                        m_st = M_IDLE;
                    end
                end
                if (press) m_req = 1'b1;
                if (m_st == M_WALK && m_rem == WALK_CYCLES - 1 && rise) m_req = 1'b0;
            end
            m_qprev = lvl_now;
            m_red_prev = rd;
            m_shist.push_back(s);
            if (m_shist.size() > DEBOUNCE_CYCLES) void'(m_shist.pop_front());
            all_diff = (m_shist.size() == DEBOUNCE_CYCLES);
            foreach (m_shist[i]) if (m_shist[i] == m_qlvl) all_diff = 1'b0;
            if (all_diff) m_qlvl = s;
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = b_i;
        end
        e.walk = (m_st == M_WALK);
        e.flt  = (m_st == M_FAULT);
        e.req  = m_req;
        e.wc   = (m_st == M_WALK || m_st == M_FLASH) ? 4'(m_rem) : 4'd0;
        case (m_st)
            M_WALK:  e.dw = 1'b0;
            M_FLASH: e.dw = (((FLASH_CYCLES - 1 - m_rem) % 2) == 0);
            M_FAULT: e.dw = ((m_fage % 2) == 0);
            default: e.dw = 1'b1;
        endcase
        exp_q.push_back(e);
    endtask

    task automatic drive_cycle(input bit r_i, input bit b_i, input bit rd, input bit yl, input bit gr);
        @(negedge clk);
        rst = r_i; ped_btn = b_i; Red = rd; Yellow = yl; Green = gr;
        model_step(r_i, b_i, rd, yl, gr);
    endtask

    task automatic run_phase(input bit rd, input bit yl, input bit gr, input int len,
                             input int btn_cycles, input bit rnd);
        logic [2:0] bad [5];
        logic [2:0] lamps;
        bit         r_i;
        bit         b_i;
        bad[0] = 3'b000; bad[1] = 3'b011; bad[2] = 3'b101; bad[3] = 3'b110; bad[4] = 3'b111;
        for (int i = 0; i < len; i++) begin
            lamps = {rd, yl, gr};
            r_i   = 1'b0;
            if (rnd) begin
                if (btn_hold > 0) btn_hold--;
                else if ($urandom_range(0, 99) < 8) btn_hold = $urandom_range(1, 6);
                b_i = (btn_hold > 0);
                if ($urandom_range(0, 99) < 2) lamps = bad[$urandom_range(0, 4)];
                if ($urandom_range(0, 999) < 4) r_i = 1'b1;
            end else begin
                b_i = (i < btn_cycles);
            end
            drive_cycle(r_i, b_i, lamps[2], lamps[1], lamps[0]);
        end
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cycle, act, req);
        end
    endtask

    // Monitor: outputs are registered, so one expectation is consumed after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("Walk", {3'd0, Walk}, {3'd0, e.walk});
                check("DontWalk", {3'd0, DontWalk}, {3'd0, e.dw});
                check("req_pending", {3'd0, req_pending}, {3'd0, e.req});
                check("fault", {3'd0, fault}, {3'd0, e.flt});
                check("walk_count", walk_count, e.wc);
            end
        end
    end

    initial begin
        // reset held two cycles
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        // press during Green, full walk and flash in the following Red
        run_phase(1'b0, 1'b0, 1'b1, 10, 5, 1'b0);
        run_phase(1'b1, 1'b0, 1'b0, 14, 0, 1'b0);
        // three quiet light cycles
        for (int k = 0; k < 3; k++) begin
            run_phase(1'b0, 1'b0, 1'b1, 6, 0, 1'b0);
            run_phase(1'b0, 1'b1, 1'b0, 2, 0, 1'b0);
            run_phase(1'b1, 1'b0, 1'b0, 6, 0, 1'b0);
        end
        // Red dropped while walk_count is 3
        run_phase(1'b0, 1'b0, 1'b1, 10, 5, 1'b0);
        run_phase(1'b1, 1'b0, 1'b0, 3, 0, 1'b0);
        run_phase(1'b0, 1'b0, 1'b1, 4, 0, 1'b0);
        // Red and Green together, then recovery
        run_phase(1'b1, 1'b0, 1'b1, 3, 0, 1'b0);
        run_phase(1'b0, 1'b0, 1'b1, 4, 0, 1'b0);
        // short two-cycle button pulse
        run_phase(1'b0, 1'b0, 1'b1, 8, 2, 1'b0);
        run_phase(1'b1, 1'b0, 1'b0, 12, 0, 1'b0);
        // randomised traffic
        for (int k = 0; k < 60; k++) begin
            run_phase(1'b0, 1'b0, 1'b1, $urandom_range(3, 12), 0, 1'b1);
            run_phase(1'b0, 1'b1, 1'b0, $urandom_range(1, 3), 0, 1'b1);
            run_phase(1'b1, 1'b0, 1'b0, $urandom_range(2, 20), 0, 1'b1);
        end
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("walk phases modelled: %0d", walks_seen);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
